// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM sequencer: FSM state encoding and sector address width.
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } bk_state_t;

  function automatic int bk_lba_w(input int sectors);
    return $clog2(sectors);
  endfunction

endpackage

// File: rtl/bk_ack_watchdog.sv
// Counts cycles spent waiting for a sector acknowledge.
// expired is high in the last allowed cycle so the request holds for exactly ACK_TIMEOUT cycles.
module bk_ack_watchdog #(
  parameter int ACK_TIMEOUT = 24'hFFFFFF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expired = run & (cnt == LAST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run & ~expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bkram_sequencer.sv
// Sequences nvram <-> save-image sector transfers: triggers, pending-write tracking,
// per-sector request/ack handshake with an ack watchdog and download abort.
module bkram_sequencer
  import bk_pkg::*;
#(
  parameter int SECTORS     = 64,
  parameter int ACK_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cart_download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_size_nz,
  input  logic        osd_status,
  input  logic        autosave_en,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        nvram_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_state,
  output logic        bk_loading,
  output logic        bk_pending,
  output logic        bk_error
);

  localparam int LBA_W = bk_lba_w(SECTORS);
  localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);

  bk_state_t        state;
  logic [LBA_W-1:0] lba;
  logic cd_q, load_q, save_q, v_q, ack_q;
  logic a_trg, l_trg, s_trg, v_trg;
  logic autosave_cond, cd_rise, ack_rise, ack_fall, pend_set, any_trg, enter_req;
  logic wd_run, wd_clr, expired;

  assign autosave_cond = bk_pending & osd_status & autosave_en;
  assign cd_rise   = cart_download & ~cd_q;
  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;
  assign pend_set  = bk_ena & ~osd_status & nvram_we;
  assign any_trg   = a_trg | l_trg | s_trg | v_trg;
  assign enter_req = ((state == IDLE) & any_trg) |
                     ((state == XFER) & ack_fall & ~cd_rise & (lba != LBA_LAST));

  assign sd_lba   = {{(32 - LBA_W){1'b0}}, lba};
  assign bk_state = (state != IDLE);
  assign wd_run   = (state == REQ);
  assign wd_clr   = (state != REQ);

  bk_ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wd (
    .clk_sys (clk_sys),
    .reset   (reset),
    .run     (wd_run),
    .clr     (wd_clr),
    .expired (expired)
  );

  // Edge pulses are registered; edges seen while busy are discarded rather than queued.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cd_q   <= 1'b0;
      load_q <= 1'b0;
      save_q <= 1'b0;
      v_q    <= 1'b0;
      ack_q  <= 1'b0;
      a_trg  <= 1'b0;
      l_trg  <= 1'b0;
      s_trg  <= 1'b0;
      v_trg  <= 1'b0;
    end else begin
      cd_q   <= cart_download;
      load_q <= load_req;
      save_q <= save_req;
      v_q    <= autosave_cond;
      ack_q  <= sd_ack;
      a_trg  <= cd_q & ~cart_download & img_size_nz & bk_ena & (state == IDLE);
      l_trg  <= load_req & ~load_q & bk_ena & (state == IDLE);
      s_trg  <= save_req & ~save_q & bk_ena & (state == IDLE);
      v_trg  <= autosave_cond & ~v_q & bk_ena & (state == IDLE);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lba        <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_ena     <= 1'b0;
      bk_loading <= 1'b0;
      bk_pending <= 1'b0;
      bk_error   <= 1'b0;
    end else begin
      if (cd_rise) begin
        bk_ena <= 1'b0;
      end else if (cart_download & img_mounted & ~img_readonly) begin
        bk_ena <= 1'b1;
      end

      if (pend_set) begin
        bk_pending <= 1'b1;
      end else if (enter_req) begin
        bk_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_trg) begin
            state      <= REQ;
            lba        <= '0;
            bk_loading <= a_trg | l_trg;
            sd_rd      <= a_trg | l_trg;
            sd_wr      <= ~(a_trg | l_trg);
            bk_error   <= 1'b0;
          end
        end
        REQ: begin
          if (cd_rise) begin
            state      <= IDLE;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
          end else if (ack_rise) begin
            state <= XFER;
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
          end else if (expired) begin
            state      <= IDLE;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_error   <= 1'b1;
            bk_loading <= 1'b0;
          end
        end
        XFER: begin
          if (cd_rise) begin
            state      <= IDLE;
            bk_loading <= 1'b0;
          end else if (ack_fall) begin
            if (lba == LBA_LAST) begin
              state      <= IDLE;
              bk_loading <= 1'b0;
            end else begin
              state <= REQ;
              lba   <= lba + 1'b1;
              sd_rd <= bk_loading;
              sd_wr <= ~bk_loading;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bkram_sequencer.sv
// Bench for bkram_sequencer: randomized hps_io ack responder plus per-scenario tasks
// checked against an expected sector list built from the transfer rules.
module tb_bkram_sequencer;

  localparam int NSEC = 64;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        cart_download = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0, img_size_nz = 1'b0;
  logic        osd_status = 1'b0, autosave_en = 1'b0, load_req = 1'b0, save_req = 1'b0;
  logic        nvram_we = 1'b0, sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_state, bk_loading, bk_pending, bk_error;

  typedef struct packed {
    logic [31:0] lba;
    logic        rd;
    logic        wr;
    logic        loading;
  } req_t;
  typedef req_t req_q_t[$];

  req_t reqs[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, proto_err = 0;
  int   ack_rise_cyc = -10, last_fall_cyc = -10;
  int   rstate = 0, wait_cnt = 0, hold_cnt = 0;
  bit   resp_en = 1'b0, prev_req = 1'b0;
  bit   pend_m = 1'b0;

  bkram_sequencer #(.SECTORS(NSEC), .ACK_TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset(reset), .cart_download(cart_download), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size_nz(img_size_nz), .osd_status(osd_status),
    .autosave_en(autosave_en), .load_req(load_req), .save_req(save_req), .nvram_we(nvram_we),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena),
    .bk_state(bk_state), .bk_loading(bk_loading), .bk_pending(bk_pending), .bk_error(bk_error)
  );

  always #5 clk_sys = ~clk_sys;

  // hps_io stand-in: random ack delay/width, logs each new request, flags handshake violations.
  always @(posedge clk_sys) begin
    bit req;
    #1;
    cyc++;
    req = sd_rd | sd_wr;
    if (sd_rd && sd_wr) proto_err++;
    if (req && !prev_req) reqs.push_back('{lba: sd_lba, rd: sd_rd, wr: sd_wr, loading: bk_loading});
    if (resp_en && cyc == ack_rise_cyc + 1 && req) proto_err++;
    if (resp_en && cyc == last_fall_cyc + 1 && bk_state && !req) proto_err++;
    prev_req = req;
    if (!resp_en) begin
      sd_ack = 1'b0;
      rstate = 0;
    end else begin
      case (rstate)
        0: if (req) begin wait_cnt = $urandom_range(0, 3); rstate = 1; end
        1: if (wait_cnt == 0) begin
             sd_ack = 1'b1; ack_rise_cyc = cyc; hold_cnt = $urandom_range(1, 4); rstate = 2;
           end else wait_cnt--;
        2: if (hold_cnt == 0) begin
             sd_ack = 1'b0; last_fall_cyc = cyc; rstate = 3;
           end else hold_cnt--;
        default: rstate = 0;
      endcase
    end
  end

  function automatic req_q_t model_xfer(input bit load);
    req_q_t q;
    req_t   e;
    for (int i = 0; i < NSEC; i++) begin
      e.lba = i; e.rd = load; e.wr = !load; e.loading = load;
      q.push_back(e);
    end
    return q;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({sd_lba, sd_rd, sd_wr, bk_ena, bk_state, bk_loading, bk_pending, bk_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got lba=%0d rd=%b wr=%b ena=%b st=%b ld=%b pend=%b err=%b want all 0",
               sd_lba, sd_rd, sd_wr, bk_ena, bk_state, bk_loading, bk_pending, bk_error);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_autoload();
    req_q_t exp;
    int fall_cyc;
    reqs.delete(); proto_err = 0; resp_en = 1'b1;
    img_size_nz = 1'b1; img_readonly = 1'b0;
    cart_download = 1'b1; step(); step();
    img_mounted = 1'b1; step(); img_mounted = 1'b0; step();
    checks++;
    if (bk_ena !== 1'b1) begin errors++; $display("FAIL autoload_ena got %b want 1", bk_ena); end
    cart_download = 1'b0;
    step();
    checks++;
    if (sd_rd !== 1'b0) begin errors++; $display("FAIL autoload_early got rd=%b want 0", sd_rd); end
    step();
    checks++;
    if ({sd_rd, sd_wr, bk_loading} !== 3'b101) begin
      errors++; $display("FAIL autoload_latency got rd/wr/ld=%b want 101", {sd_rd, sd_wr, bk_loading});
    end
    fall_cyc = -1;
    for (int n = 0; n < 3000 && bk_state; n++) begin
      step();
      if (!bk_loading && fall_cyc < 0) fall_cyc = cyc;
    end
    checks++;
    if (bk_state !== 1'b0) begin errors++; $display("FAIL autoload_done got bk_state=%b want 0", bk_state); end
    checks++;
    if (fall_cyc - last_fall_cyc !== 1) begin
      errors++; $display("FAIL autoload_loading_fall got %0d cycles want 1", fall_cyc - last_fall_cyc);
    end
    exp = model_xfer(1'b1);
    checks++;
    if (reqs.size() !== exp.size()) begin
      errors++; $display("FAIL autoload_count got %0d want %0d", reqs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < reqs.size(); i++) begin
      checks++;
      if (reqs[i] !== exp[i]) begin errors++; $display("FAIL autoload_req%0d got %h want %h", i, reqs[i], exp[i]); end
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL autoload_handshake got %0d violations want 0", proto_err); end
  endtask

  task automatic test_save_pending();
    req_q_t exp;
    reqs.delete(); proto_err = 0; autosave_en = 1'b0; pend_m = 1'b0;
    for (int n = 0; n < 12; n++) begin
      osd_status = 1'($urandom_range(0, 1));
      nvram_we   = 1'($urandom_range(0, 1));
      step();
      if (nvram_we && !osd_status) pend_m = 1'b1;
      checks++;
      if (bk_pending !== pend_m) begin errors++; $display("FAIL pending_rand%0d got %b want %b", n, bk_pending, pend_m); end
    end
    osd_status = 1'b0; nvram_we = 1'b1; step(); nvram_we = 1'b0; pend_m = 1'b1;
    checks++;
    if (bk_pending !== pend_m) begin errors++; $display("FAIL pending_set got %b want 1", bk_pending); end
    save_req = 1'b1; step(); step();
    pend_m = 1'b0;
    checks++;
    if ({sd_rd, sd_wr, bk_pending} !== {2'b01, pend_m}) begin
      errors++; $display("FAIL save_start got rd/wr/pend=%b want 010", {sd_rd, sd_wr, bk_pending});
    end
    save_req = 1'b0;
    for (int n = 0; n < 3000 && bk_state; n++) step();
    exp = model_xfer(1'b0);
    checks++;
    if (reqs.size() !== exp.size()) begin errors++; $display("FAIL save_count got %0d want %0d", reqs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < reqs.size(); i++) begin
      checks++;
      if (reqs[i] !== exp[i]) begin errors++; $display("FAIL save_req%0d got %h want %h", i, reqs[i], exp[i]); end
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL save_handshake got %0d violations want 0", proto_err); end
  endtask

  task automatic test_autosave();
    req_q_t exp;
    int busy;
    reqs.delete(); proto_err = 0; autosave_en = 1'b1; osd_status = 1'b0;
    nvram_we = 1'b1; step(); nvram_we = 1'b0; step();
    checks++;
    if (bk_pending !== 1'b1) begin errors++; $display("FAIL autosave_pending got %b want 1", bk_pending); end
    osd_status = 1'b1; step(); step();
    checks++;
    if ({sd_rd, sd_wr} !== 2'b01) begin errors++; $display("FAIL autosave_start got rd/wr=%b want 01", {sd_rd, sd_wr}); end
    for (int n = 0; n < 3000 && bk_state; n++) step();
    busy = 0;
    for (int n = 0; n < 60; n++) begin step(); if (bk_state) busy++; end
    exp = model_xfer(1'b0);
    checks++;
    if (reqs.size() !== exp.size()) begin errors++; $display("FAIL autosave_count got %0d want %0d", reqs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < reqs.size(); i++) begin
      checks++;
      if (reqs[i] !== exp[i]) begin errors++; $display("FAIL autosave_req%0d got %h want %h", i, reqs[i], exp[i]); end
    end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL autosave_retrigger got %0d busy cycles want 0", busy); end
    osd_status = 1'b0; autosave_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    req_q_t exp;
    reqs.delete(); proto_err = 0;
    load_req = 1'b1; save_req = 1'b1; step(); step();
    checks++;
    if ({sd_rd, sd_wr, bk_loading} !== 3'b101) begin
      errors++; $display("FAIL simul_winner got rd/wr/ld=%b want 101", {sd_rd, sd_wr, bk_loading});
    end
    repeat (10) step();
    save_req = 1'b0;
    repeat (5) step();
    save_req = 1'b1;
    for (int n = 0; n < 3000 && bk_state; n++) step();
    repeat (20) step();
    exp = model_xfer(1'b1);
    checks++;
    if (reqs.size() !== exp.size()) begin errors++; $display("FAIL simul_count got %0d want %0d", reqs.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < reqs.size(); i++) begin
      checks++;
      if (reqs[i] !== exp[i]) begin errors++; $display("FAIL simul_req%0d got %h want %h", i, reqs[i], exp[i]); end
    end
    load_req = 1'b0; save_req = 1'b0; step();
  endtask

  task automatic test_timeout();
    int n;
    reqs.delete(); resp_en = 1'b0;
    load_req = 1'b1; step(); step();
    n = 0;
    while (sd_rd && n < 40) begin n++; step(); end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL timeout_len got %0d cycles want 16", n); end
    checks++;
    if ({bk_error, bk_state, bk_loading, sd_rd} !== 4'b1000) begin
      errors++; $display("FAIL timeout_state got err/st/ld/rd=%b want 1000", {bk_error, bk_state, bk_loading, sd_rd});
    end
    load_req = 1'b0; step();
    resp_en = 1'b1; save_req = 1'b1; step(); step();
    checks++;
    if ({bk_error, sd_wr} !== 2'b01) begin errors++; $display("FAIL timeout_clear got err/wr=%b want 01", {bk_error, sd_wr}); end
    save_req = 1'b0;
    for (int k = 0; k < 3000 && bk_state; k++) step();
    checks++;
    if ({bk_state, bk_error} !== 2'b00) begin errors++; $display("FAIL timeout_recover got st/err=%b want 00", {bk_state, bk_error}); end
  endtask

  task automatic test_reset_midop();
    bit found;
    int busy;
    reqs.delete(); resp_en = 1'b1;
    load_req = 1'b1; step(); step(); load_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (sd_lba == 10 && bk_state && !sd_rd && !sd_wr) begin found = 1'b1; break; end
      step();
    end
    checks++;
    if (!found || bk_loading !== 1'b1) begin errors++; $display("FAIL midop_reach got found=%b ld=%b want 1 1", found, bk_loading); end
    reset = 1'b1;
    #1;
    checks++;
    if ({sd_lba, sd_rd, sd_wr, bk_ena, bk_state, bk_loading, bk_pending, bk_error} !== '0) begin
      errors++; $display("FAIL midop_async got lba=%0d rd=%b wr=%b st=%b ld=%b want all 0", sd_lba, sd_rd, sd_wr, bk_state, bk_loading);
    end
    resp_en = 1'b0; step(); step(); reset = 1'b0;
    busy = 0;
    for (int n = 0; n < 40; n++) begin step(); if (sd_rd | sd_wr | bk_state) busy++; end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL midop_resume got %0d busy cycles want 0", busy); end
    cart_download = 1'b1; img_readonly = 1'b1; step();
    img_mounted = 1'b1; step(); img_mounted = 1'b0; step();
    checks++;
    if (bk_ena !== 1'b0) begin errors++; $display("FAIL readonly_ena got %b want 0", bk_ena); end
    cart_download = 1'b0; step();
    save_req = 1'b1; busy = 0;
    for (int n = 0; n < 10; n++) begin step(); if (sd_rd | sd_wr | bk_state) busy++; end
    save_req = 1'b0; img_readonly = 1'b0;
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL readonly_save got %0d busy cycles want 0", busy); end
  endtask

  task automatic test_download_abort();
    bit found;
    int busy;
    resp_en = 1'b1;
    cart_download = 1'b1; step();
    img_mounted = 1'b1; step(); img_mounted = 1'b0; step();
    cart_download = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (sd_lba == 3 && bk_state) begin found = 1'b1; break; end
    end
    cart_download = 1'b1; step();
    checks++;
    if (!found || {bk_state, sd_rd, sd_wr, bk_loading, bk_error, bk_ena} !== 6'b0) begin
      errors++; $display("FAIL abort_state got found=%b st/rd/wr/ld/err/ena=%b want 1 000000",
                         found, {bk_state, sd_rd, sd_wr, bk_loading, bk_error, bk_ena});
    end
    cart_download = 1'b0; busy = 0;
    for (int n = 0; n < 20; n++) begin step(); if (bk_state) busy++; end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL abort_reload got %0d busy cycles want 0", busy); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_autoload();
    test_save_pending();
    test_autosave();
    test_simultaneous();
    test_timeout();
    test_reset_midop();
    test_download_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
